openram_packet_driver: RTL

// - Command-side initiator for the OpenRAM test chip packet interface.
// - Accepts single SRAM ops on a valid/ready command port.
// - Formats each op into the 56-bit {chip_select, packet} word the test chip decodes, and holds it stable for the SRAM access.
// - Samples the test chip's 32-bit sram_data return and hands read results back on a valid/ready response port.
// - Sits in user logic next to the test chip; its output feeds the gpio_packet/analyzer_packet inputs.

---
 rtl/openram_pkt_pkg.sv | 38 +++
 rtl/openram_pkt_format.sv | 40 ++++
 rtl/openram_packet_driver.sv | 120 ++++++++++++
 3 files changed

// File: rtl/openram_pkt_pkg.sv
// Shared definitions for the OpenRAM test chip packet interface: field
// positions of the 56-bit {chip_select, packet} word, op encodings, FSM states.
package openram_pkt_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;
   localparam int PKT_W  = 56;

   localparam int CS_BIT     = 55;
   localparam int CSB0_BIT   = 54;
   localparam int WEB0_BIT   = 53;
   localparam int WMASK0_LSB = 49;
   localparam int ADDR0_LSB  = 41;
   localparam int DIN0_LSB   = 9;
   localparam int CSB1_BIT   = 8;
   localparam int ADDR1_LSB  = 0;

   // Both ports deselected, port 0 in read mode, every other field zero.
   localparam logic [PKT_W-1:0] IDLE_PKT = (56'd1 << CSB0_BIT)
                                         | (56'd1 << WEB0_BIT)
                                         | (56'd1 << CSB1_BIT);

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_READ0 = 2'b01,
      OP_READ1 = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_e;

endpackage

// File: rtl/openram_pkt_format.sv
// Combinational formatter: one SRAM op -> the 56-bit word the test chip decodes.
// Kept standalone so the receive-side checker can reuse the exact encoding.
module openram_pkt_format
   import openram_pkt_pkg::*;
(
   input  op_e               op,
   input  logic              sram,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [MASK_W-1:0] wmask,
   output logic [PKT_W-1:0]  word
);

   // NOTE: word gets a full default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      word = IDLE_PKT;
      case (op)
         OP_WRITE: begin
            word[CS_BIT]                      = sram;
            word[CSB0_BIT]                    = 1'b0;
            word[WEB0_BIT]                    = 1'b0;
            word[WMASK0_LSB +: MASK_W]        = wmask;
            word[ADDR0_LSB +: ADDR_W]         = addr;
            word[DIN0_LSB +: DATA_W]          = wdata;
         end
         OP_READ0: begin
            word[CS_BIT]                      = sram;
            word[CSB0_BIT]                    = 1'b0;
            word[ADDR0_LSB +: ADDR_W]         = addr;
         end
         OP_READ1: begin
            word[CS_BIT]                      = sram;
            word[CSB1_BIT]                    = 1'b0;
            word[ADDR1_LSB +: ADDR_W]         = addr;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/openram_packet_driver.sv
// Command-side initiator for the OpenRAM test chip: issues one SRAM op at a time
// as a held packet word and returns read data on a valid/ready response port.
module openram_packet_driver
   import openram_pkt_pkg::*;
#(
   parameter int RD_LATENCY = 2
) (
   input  logic              clk_in,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic              cmd_sram,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [MASK_W-1:0] cmd_wmask,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [PKT_W-1:0]  packet_out,
   input  logic [DATA_W-1:0] sram_data_in,
   output logic              busy
);

   localparam int               CNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LATENCY - 1);

   state_e           state_q, state_d;
   op_e              op;
   logic [PKT_W-1:0] fmt_word;
   logic [CNT_W-1:0] cnt_q;
   logic             is_read_q;
   logic             load_pkt, clear_pkt, capture_rsp, drop_rsp, cnt_inc;

   assign op = op_e'(cmd_op);

   openram_pkt_format u_format (
      .op    (op),
      .sram  (cmd_sram),
      .addr  (cmd_addr),
      .wdata (cmd_wdata),
      .wmask (cmd_wmask),
      .word  (fmt_word)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // cnt_q counts packet-held cycles; the read is sampled at the end of the last one.
   always_comb begin
      state_d     = state_q;
      cmd_ready   = 1'b0;
      busy        = 1'b1;
      load_pkt    = 1'b0;
      clear_pkt   = 1'b0;
      capture_rsp = 1'b0;
      drop_rsp    = 1'b0;
      cnt_inc     = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid && op != OP_RSVD) begin
               load_pkt = 1'b1;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE, S_WAIT: begin
            if (!is_read_q) begin
               clear_pkt = 1'b1;
               state_d   = S_IDLE;
            end else if (cnt_q == LAST_CNT) begin
               capture_rsp = 1'b1;
               clear_pkt   = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_inc = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               drop_rsp = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: packet_out resets asynchronously so the chip sees IDLE_PKT the moment reset_n falls.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         packet_out <= IDLE_PKT;
         is_read_q  <= 1'b0;
         cnt_q      <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
      end else begin
         if (load_pkt) begin
            packet_out <= fmt_word;
            is_read_q  <= (op != OP_WRITE);
            cnt_q      <= '0;
         end else begin
            if (clear_pkt) packet_out <= IDLE_PKT;
            if (cnt_inc)   cnt_q      <= cnt_q + CNT_W'(1);
         end
         if (capture_rsp) begin
            rsp_data  <= sram_data_in;
            rsp_valid <= 1'b1;
         end else if (drop_rsp) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule
